// File: rtl/booth_multiplier_seq.sv
// Sequential radix-4 Booth multiplier, WIDTH x WIDTH -> 2*WIDTH, signed or unsigned.
// One recoded multiplier bit-pair is retired per RUN cycle into a shifting accumulator.
// Optional macro BOOTH_EARLY_TERM_EN: finish as soon as every remaining recode is zero.
module booth_multiplier_seq #(
  parameter int WIDTH = 32
) (
  input  logic               in_clk,
  input  logic               in_rst,
  input  logic               in_start,
  input  logic               in_signed,
  input  logic [WIDTH-1:0]   in_multiplicand,
  input  logic [WIDTH-1:0]   in_multiplier,
  output logic               out_busy,
  output logic               out_done,
  output logic [2*WIDTH-1:0] out_product
);
  localparam int XW   = WIDTH + 2;       // extended operand width
  localparam int AW   = WIDTH + 3;       // addend / accumulator upper-half width
  localparam int NMAX = WIDTH / 2 + 1;   // step count in unsigned mode
  localparam int PW   = AW + 2 * NMAX;   // full accumulator: upper half plus shifted-out bits
  localparam int CW   = $clog2(NMAX + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state, state_nx;
  logic [XW-1:0]        m_reg, q_reg, q_step;
  logic                 q_m1, qm1_step, sgn, stop;
  logic [CW-1:0]        cnt, last_idx;
  logic signed [PW-1:0] acc, acc_sum, acc_step;
  logic [AW-1:0]        m_x, neg_m, addend;
  logic [2*WIDTH-1:0]   product, product_nx;
  int                   shamt;

  // Recode the current bit triplet and form the next accumulator / multiplier values
  always_comb begin
    m_x    = {m_reg[XW-1], m_reg};
    neg_m  = ~m_x + 1'b1;
    addend = '0;
    case ({q_reg[1:0], q_m1})
      3'b001, 3'b010: addend = m_x;
      3'b011:         addend = m_x << 1;
      3'b100:         addend = neg_m << 1;
      3'b101, 3'b110: addend = neg_m;
      default:        addend = '0;
    endcase
    // addend lands on the upper half; the low 2*NMAX bits collect shifted-out product bits
    acc_sum  = acc + $signed({addend, {(2 * NMAX){1'b0}}});
    acc_step = acc_sum >>> 2;
    q_step   = {q_reg[XW-1], q_reg[XW-1], q_reg[XW-1:2]};
    qm1_step = q_reg[1];
    last_idx = sgn ? CW'(WIDTH / 2 - 1) : CW'(NMAX - 1);
`ifdef BOOTH_EARLY_TERM_EN
    // remaining pairs all recode to 0 when Q and lookback are all-zero (or all-one if signed)
    stop  = (cnt == last_idx) ||
            ((q_step == '0) && !qm1_step) ||
            (sgn && (&q_step) && qm1_step);
    // every skipped step is a skipped 2-bit shift still owed to the product alignment
    shamt = 2 * (NMAX - 1 - int'(cnt));
`else
    stop  = (cnt == last_idx);
    // signed mode runs one step fewer than the accumulator is sized for
    shamt = sgn ? 2 : 0;
`endif
    product_nx = (2 * WIDTH)'(acc_step >>> shamt);
  end

  // State register
  always_ff @(posedge in_clk) begin
    if (in_rst) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state and handshake outputs
  always_comb begin
    state_nx = state;
    out_busy = 1'b0;
    out_done = 1'b0;
    case (state)
      IDLE: if (in_start) state_nx = RUN;
      RUN: begin
        out_busy = 1'b1;
        if (stop) state_nx = DONE;
      end
      DONE: begin
        out_done = 1'b1;
        state_nx = in_start ? RUN : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: capture operands on an accepted start, step the accumulator while running
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      m_reg   <= '0;
      q_reg   <= '0;
      q_m1    <= 1'b0;
      sgn     <= 1'b0;
      cnt     <= '0;
      acc     <= '0;
      product <= '0;
    end else if (state != RUN) begin
      if (in_start) begin
        m_reg <= in_signed ? {{2{in_multiplicand[WIDTH-1]}}, in_multiplicand}
                           : {2'b00, in_multiplicand};
        q_reg <= in_signed ? {{2{in_multiplier[WIDTH-1]}}, in_multiplier}
                           : {2'b00, in_multiplier};
        q_m1  <= 1'b0;
        sgn   <= in_signed;
        cnt   <= '0;
        acc   <= '0;
      end
    end else begin
      acc   <= acc_step;
      q_reg <= q_step;
      q_m1  <= qm1_step;
      cnt   <= cnt + 1'b1;
      if (stop) product <= product_nx;
    end
  end

  assign out_product = product;
endmodule
